prbs_lock_ctrl: RTL and testbench

Sequencing and monitoring controller for a PRBS checker datapath. It consumes the checker's per-word valid/right result stream and runs a hunt/lock state machine. In locked state it accumulates word and error counts over a programmable test length and tracks loss-of-lock events. It sits between the PRBS checker and the register/status interface of a link-test subsystem.

---
 rtl/prbs_lock_ctrl.sv | 139 +++++++++++++
 tb/tb_prbs_lock_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_lock_ctrl.sv
// Hunt/lock sequencer for a PRBS checker result stream, with saturating word, error
// and loss-of-lock counters accumulated while locked.
`timescale 1ns/1ps
module prbs_lock_ctrl #(
  parameter int unsigned C_LOCK_CNT   = 8,
  parameter int unsigned C_UNLOCK_CNT = 4,
  parameter int unsigned C_CNT_WIDTH  = 32,
  parameter int unsigned C_TEST_WORDS = 0
) (
  input  logic                   I_clk,
  input  logic                   I_rst_n,
  input  logic                   I_start,
  input  logic                   I_stop,
  input  logic                   I_check_v,
  input  logic                   I_check_right,
  output logic [1:0]             O_state,
  output logic                   O_locked,
  output logic                   O_done,
  output logic [C_CNT_WIDTH-1:0] O_word_cnt,
  output logic [C_CNT_WIDTH-1:0] O_err_cnt,
  output logic [7:0]             O_lost_cnt,
  output logic                   O_err_pulse
);

  localparam int unsigned RunMax = (C_LOCK_CNT > C_UNLOCK_CNT) ? C_LOCK_CNT : C_UNLOCK_CNT;
  localparam int unsigned RunW   = $clog2(RunMax) + 1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHunt   = 2'd1,
    StLocked = 2'd2,
    StDone   = 2'd3
  } state_e;

  state_e                 r_state, w_state_nxt;
  logic [C_CNT_WIDTH-1:0] r_word_cnt, w_word_nxt, w_word_inc;
  logic [C_CNT_WIDTH-1:0] r_err_cnt, w_err_nxt, w_err_inc;
  logic [7:0]             r_lost_cnt, w_lost_nxt, w_lost_inc;
  logic [RunW-1:0]        r_good_run, w_good_nxt, w_good_inc;
  logic [RunW-1:0]        r_bad_run, w_bad_nxt, w_bad_inc;
  logic                   r_err_pulse, w_pulse_nxt;
  logic                   r_locked, r_done;

  // Saturating increments; counters never wrap.
  assign w_word_inc = (r_word_cnt == '1) ? r_word_cnt : r_word_cnt + 1'b1;
  assign w_err_inc  = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + 1'b1;
  assign w_lost_inc = (r_lost_cnt == 8'hFF) ? r_lost_cnt : r_lost_cnt + 1'b1;
  assign w_good_inc = r_good_run + 1'b1;
  assign w_bad_inc  = r_bad_run + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word_cnt;
    w_err_nxt   = r_err_cnt;
    w_lost_nxt  = r_lost_cnt;
    w_good_nxt  = r_good_run;
    w_bad_nxt   = r_bad_run;
    w_pulse_nxt = 1'b0;
    if (I_start) begin
      w_state_nxt = StHunt;
      w_word_nxt  = '0;
      w_err_nxt   = '0;
      w_lost_nxt  = '0;
      w_good_nxt  = '0;
      w_bad_nxt   = '0;
    end else if (I_stop) begin
      w_state_nxt = StIdle;
    end else if (I_check_v) begin
      case (r_state)
        StHunt: begin
          if (I_check_right) begin
            w_good_nxt = w_good_inc;
            if (w_good_inc == RunW'(C_LOCK_CNT)) begin
              w_state_nxt = StLocked;
              w_good_nxt  = '0;
              w_bad_nxt   = '0;
            end
          end else begin
            w_good_nxt = '0;
          end
        end
        StLocked: begin
          w_word_nxt = w_word_inc;
          if (!I_check_right) begin
            w_err_nxt   = w_err_inc;
            w_pulse_nxt = 1'b1;
            w_bad_nxt   = w_bad_inc;
            if (w_bad_inc == RunW'(C_UNLOCK_CNT)) begin
              w_state_nxt = StHunt;
              w_lost_nxt  = w_lost_inc;
              w_good_nxt  = '0;
              w_bad_nxt   = '0;
            end
          end else begin
            w_bad_nxt = '0;
          end
          // Test end overrides a coincident loss of lock; the loss is still counted.
          if ((C_TEST_WORDS != 0) && (w_word_inc == C_CNT_WIDTH'(C_TEST_WORDS))) begin
            w_state_nxt = StDone;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state     <= StIdle;
      r_word_cnt  <= '0;
      r_err_cnt   <= '0;
      r_lost_cnt  <= '0;
      r_good_run  <= '0;
      r_bad_run   <= '0;
      r_err_pulse <= 1'b0;
      r_locked    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_word_cnt  <= w_word_nxt;
      r_err_cnt   <= w_err_nxt;
      r_lost_cnt  <= w_lost_nxt;
      r_good_run  <= w_good_nxt;
      r_bad_run   <= w_bad_nxt;
      r_err_pulse <= w_pulse_nxt;
      r_locked    <= (w_state_nxt == StLocked);
      r_done      <= (w_state_nxt == StDone);
    end
  end

  assign O_state     = r_state;
  assign O_locked    = r_locked;
  assign O_done      = r_done;
  assign O_word_cnt  = r_word_cnt;
  assign O_err_cnt   = r_err_cnt;
  assign O_lost_cnt  = r_lost_cnt;
  assign O_err_pulse = r_err_pulse;

endmodule

// File: tb/tb_prbs_lock_ctrl.sv
// Bench for prbs_lock_ctrl: four differently parameterised instances share one stimulus
// stream and are compared every cycle against a plain-integer behavioural model.
`timescale 1ns/1ps
module tb_prbs_lock_ctrl;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, chk_v = 1'b0, chk_r = 1'b0;

  always #5 clk = ~clk;

  logic [1:0]  o_state[N];
  logic        o_locked[N], o_done[N], o_pulse[N];
  logic [31:0] o_word[N], o_err[N];
  logic [7:0]  o_lost[N];
  logic [3:0]  d_word, d_err;

  assign o_word[3] = {28'd0, d_word};
  assign o_err[3]  = {28'd0, d_err};

  prbs_lock_ctrl #(.C_LOCK_CNT(8), .C_UNLOCK_CNT(4), .C_CNT_WIDTH(32), .C_TEST_WORDS(0)) u_a (
    .I_clk(clk), .I_rst_n(rst_n), .I_start(start), .I_stop(stop), .I_check_v(chk_v),
    .I_check_right(chk_r), .O_state(o_state[0]), .O_locked(o_locked[0]), .O_done(o_done[0]),
    .O_word_cnt(o_word[0]), .O_err_cnt(o_err[0]), .O_lost_cnt(o_lost[0]),
    .O_err_pulse(o_pulse[0])
  );
  prbs_lock_ctrl #(.C_LOCK_CNT(8), .C_UNLOCK_CNT(4), .C_CNT_WIDTH(32), .C_TEST_WORDS(100)) u_b (
    .I_clk(clk), .I_rst_n(rst_n), .I_start(start), .I_stop(stop), .I_check_v(chk_v),
    .I_check_right(chk_r), .O_state(o_state[1]), .O_locked(o_locked[1]), .O_done(o_done[1]),
    .O_word_cnt(o_word[1]), .O_err_cnt(o_err[1]), .O_lost_cnt(o_lost[1]),
    .O_err_pulse(o_pulse[1])
  );
  prbs_lock_ctrl #(.C_LOCK_CNT(8), .C_UNLOCK_CNT(4), .C_CNT_WIDTH(32), .C_TEST_WORDS(20)) u_c (
    .I_clk(clk), .I_rst_n(rst_n), .I_start(start), .I_stop(stop), .I_check_v(chk_v),
    .I_check_right(chk_r), .O_state(o_state[2]), .O_locked(o_locked[2]), .O_done(o_done[2]),
    .O_word_cnt(o_word[2]), .O_err_cnt(o_err[2]), .O_lost_cnt(o_lost[2]),
    .O_err_pulse(o_pulse[2])
  );
  prbs_lock_ctrl #(.C_LOCK_CNT(1), .C_UNLOCK_CNT(1), .C_CNT_WIDTH(4), .C_TEST_WORDS(0)) u_d (
    .I_clk(clk), .I_rst_n(rst_n), .I_start(start), .I_stop(stop), .I_check_v(chk_v),
    .I_check_right(chk_r), .O_state(o_state[3]), .O_locked(o_locked[3]), .O_done(o_done[3]),
    .O_word_cnt(d_word), .O_err_cnt(d_err), .O_lost_cnt(o_lost[3]),
    .O_err_pulse(o_pulse[3])
  );

  int p_lock[N]   = '{8, 8, 8, 1};
  int p_unlock[N] = '{4, 4, 4, 1};
  int p_tw[N]     = '{0, 100, 20, 0};
  int p_w[N]      = '{32, 32, 32, 4};

  // Model state: 0 idle, 1 hunt, 2 locked, 3 done.
  int     m_state[N], m_lost[N], m_good[N], m_bad[N], m_pulse[N];
  longint m_word[N], m_err[N];

  int n_tests = 0;
  int n_fail  = 0;
  int pulses;

  task automatic check(input string name, input int k, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_state[k] = 0; m_word[k] = 0; m_err[k] = 0; m_lost[k] = 0;
      m_good[k] = 0; m_bad[k] = 0; m_pulse[k] = 0;
    end
  endtask

  task automatic model_step();
    longint wmax;
    for (int k = 0; k < N; k++) begin
      wmax = (64'd1 << p_w[k]) - 1;
      m_pulse[k] = 0;
      if (start) begin
        m_state[k] = 1; m_word[k] = 0; m_err[k] = 0; m_lost[k] = 0;
        m_good[k] = 0; m_bad[k] = 0;
      end else if (stop) begin
        m_state[k] = 0;
      end else if (chk_v && m_state[k] == 1) begin
        m_good[k] = chk_r ? m_good[k] + 1 : 0;
        if (m_good[k] == p_lock[k]) begin
          m_state[k] = 2; m_good[k] = 0; m_bad[k] = 0;
        end
      end else if (chk_v && m_state[k] == 2) begin
        if (m_word[k] < wmax) m_word[k]++;
        if (chk_r) m_bad[k] = 0;
        else begin
          if (m_err[k] < wmax) m_err[k]++;
          m_pulse[k] = 1;
          m_bad[k]++;
          if (m_bad[k] == p_unlock[k]) begin
            if (m_lost[k] < 255) m_lost[k]++;
            m_state[k] = 1; m_good[k] = 0; m_bad[k] = 0;
          end
        end
        if (p_tw[k] != 0 && m_word[k] == p_tw[k]) m_state[k] = 3;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < N; k++) begin
      check("state", k, o_state[k], m_state[k]);
      check("locked", k, o_locked[k], m_state[k] == 2);
      check("done", k, o_done[k], m_state[k] == 3);
      check("word_cnt", k, o_word[k], m_word[k]);
      check("err_cnt", k, o_err[k], m_err[k]);
      check("lost_cnt", k, o_lost[k], m_lost[k]);
      check("err_pulse", k, o_pulse[k], m_pulse[k]);
    end
  endtask

  // One clock of stimulus; model advances on the same edge, outputs compared just after.
  task automatic drive(input logic s, input logic p, input logic v, input logic r);
    @(negedge clk);
    start = s; stop = p; chk_v = v; chk_r = r;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic rights(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic wrongs(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  int rates[4] = '{0, 3, 25, 60};

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_state", 0, o_state[0], 0);
    check("rst_word", 0, o_word[0], 0);
    rst_n = 1'b1;

    // Lock needs 8 consecutive rights; a wrong restarts the run.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    rights(7);
    wrongs(1);
    rights(7);
    check("hunt_15", 0, o_state[0], 1);
    rights(1);
    check("lock_16", 0, o_state[0], 2);
    check("lock_locked", 0, o_locked[0], 1);
    check("lock_word", 0, o_word[0], 0);
    rights(37);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("word_37", 0, o_word[0], 37);

    // Asynchronous reset takes effect without a clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", 0, o_state[0], 0);
    check("arst_word", 0, o_word[0], 0);
    check("arst_locked", 0, o_locked[0], 0);
    model_reset();
    #1 rst_n = 1'b1;

    // 100-word test with errors at samples 10, 11, 50.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    rights(8);
    pulses = 0;
    for (int i = 1; i <= 100; i++) begin
      drive(1'b0, 1'b0, 1'b1, !(i == 10 || i == 11 || i == 50));
      if (o_pulse[1] === 1'b1) pulses++;
    end
    check("t100_done", 1, o_done[1], 1);
    check("t100_err", 1, o_err[1], 3);
    check("t100_word", 1, o_word[1], 100);
    check("t100_lost", 1, o_lost[1], 0);
    check("t100_pulses", 1, pulses, 3);

    // Loss of lock after 4 consecutive wrongs.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    rights(8);
    wrongs(3);
    check("unlock_3", 0, o_state[0], 2);
    wrongs(1);
    check("unlock_state", 0, o_state[0], 1);
    check("unlock_lost", 0, o_lost[0], 1);
    check("unlock_err", 0, o_err[0], 4);
    wrongs(3);
    rights(1);
    check("hunt_after", 0, o_state[0], 1);
    check("hunt_lost", 0, o_lost[0], 1);

    // Test end coinciding with unlock: DONE wins, loss still counted.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    rights(8 + 16);
    wrongs(4);
    check("t20_state", 2, o_state[2], 3);
    check("t20_done", 2, o_done[2], 1);
    check("t20_lost", 2, o_lost[2], 1);
    check("t20_word", 2, o_word[2], 20);

    // Start beats stop; stop alone holds counters and drops its sample.
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    check("ss_state", 2, o_state[2], 1);
    check("ss_word", 2, o_word[2], 0);
    check("ss_lost", 2, o_lost[2], 0);
    rights(8 + 3);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    check("stop_state", 2, o_state[2], 0);
    check("stop_word", 2, o_word[2], 3);
    check("stop_err", 2, o_err[2], 0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("idle_word", 2, o_word[2], 3);

    // Invalid gaps leave the good run untouched.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    rights(4);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'($urandom_range(1)));
    rights(3);
    check("gap_hunt", 0, o_state[0], 1);
    rights(1);
    check("gap_lock", 0, o_state[0], 2);

    // Saturation on the narrow single-word-lock instance.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      rights(1);
      wrongs(1);
    end
    check("sat_lost", 3, o_lost[3], 255);
    check("sat_word", 3, o_word[3], 15);
    check("sat_err", 3, o_err[3], 15);

    // Randomised traffic with error rate varying per segment.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(149) == 0), 1'($urandom_range(249) == 0),
            1'($urandom_range(3) != 0), 1'($urandom_range(99) >= rates[(i / 200) % 4]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
